// File: rtl/ikaopll_frame_mixer.sv
// Frame mixer: weights time-multiplexed slot samples by group volume,
// accumulates one frame and emits a saturated strobed sample.
module ikaopll_frame_mixer #(
  parameter  int NUM_SLOTS  = 18,
  parameter  int NUM_GROUPS = 2,
  parameter  int DATA_WIDTH = 9,
  parameter  int VOL_WIDTH  = 5,
  parameter  int OUT_WIDTH  = 16,
  parameter  int SHIFT      = 0,
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                            i_EMUCLK,
  input  logic                            i_RST_n,
  input  logic                            i_phi1_NCEN_n,
  input  logic                            i_FRAME_START,
  input  logic                            i_SLOT_VALID,
  input  logic [GW-1:0]                   i_SLOT_GROUP,
  input  logic [DATA_WIDTH-1:0]           i_DATA,
  input  logic [NUM_GROUPS*VOL_WIDTH-1:0] i_VOL,
  input  logic [NUM_GROUPS-1:0]           i_MUTE,
  output logic                            o_ACC_STRB,
  output logic [OUT_WIDTH-1:0]            o_ACC,
  output logic                            o_CLIP,
  output logic                            o_FRAME_ERR
);

  localparam int PW = DATA_WIDTH + VOL_WIDTH;
  localparam int AW = PW + $clog2(NUM_SLOTS + 1);
  localparam int CW = $clog2(NUM_SLOTS + 2);
  localparam int EW = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  logic en;
  assign en = !i_phi1_NCEN_n;

  logic        [VOL_WIDTH-1:0] vol_sel;
  logic                        muted;
  logic signed [PW-1:0]        data_x;
  logic signed [PW-1:0]        vol_x;
  logic signed [PW-1:0]        mul;
  logic signed [PW-1:0]        prod_c;

  // Out-of-range groups never match and therefore read as muted.
  always_comb begin
    vol_sel = '0;
    muted   = 1'b1;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (i_SLOT_GROUP == GW'(g)) begin
        vol_sel = i_VOL[g*VOL_WIDTH +: VOL_WIDTH];
        muted   = i_MUTE[g];
      end
    end
  end

  assign data_x = {{VOL_WIDTH{i_DATA[DATA_WIDTH-1]}}, i_DATA};
  assign vol_x  = {{DATA_WIDTH{vol_sel[VOL_WIDTH-1]}}, vol_sel};
  assign mul    = data_x * vol_x;
  assign prod_c = (i_SLOT_VALID && !muted) ? mul : '0;

  logic signed [PW-1:0] s1_prod;
  logic                 s1_valid;
  logic                 s1_fs;

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      s1_prod  <= '0;
      s1_valid <= 1'b0;
      s1_fs    <= 1'b0;
    end else if (en) begin
      s1_prod  <= prod_c;
      s1_valid <= i_SLOT_VALID;
      s1_fs    <= i_FRAME_START;
    end
  end

  state_t               state, state_n;
  logic signed [AW-1:0] acc, acc_n;
  logic        [CW-1:0] cnt, cnt_n;
  logic                 close;

  logic signed [AW-1:0]        prod_x;
  logic signed [AW-1:0]        acc_sh;
  logic signed [EW-1:0]        s_ext;
  logic signed [EW-1:0]        max_v;
  logic signed [EW-1:0]        min_v;
  logic                        gt, lt;
  logic        [OUT_WIDTH-1:0] sat_c;

  assign prod_x = {{(AW-PW){s1_prod[PW-1]}}, s1_prod};
  assign acc_sh = acc >>> SHIFT;
  assign s_ext  = {{(EW-AW){acc_sh[AW-1]}}, acc_sh};
  assign max_v  = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  assign min_v  = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  assign gt     = s_ext > max_v;
  assign lt     = s_ext < min_v;

  always_comb begin
    sat_c = s_ext[OUT_WIDTH-1:0];
    if (gt) sat_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    if (lt) sat_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    close   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s1_fs) begin
          state_n = ACCUM;
          acc_n   = prod_x;
          cnt_n   = CW'(s1_valid);
        end
      end
      ACCUM: begin
        if (s1_fs) begin
          close = 1'b1;
          acc_n = prod_x;
          cnt_n = CW'(s1_valid);
        end else begin
          acc_n = acc + prod_x;
          if (cnt != CW'(NUM_SLOTS + 1))
            cnt_n = cnt + CW'(s1_valid);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The strobe is re-evaluated every clock so it always drops after one cycle.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      o_ACC_STRB  <= 1'b0;
      o_ACC       <= '0;
      o_CLIP      <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      o_ACC_STRB <= en && close;
      if (en) begin
        state <= state_n;
        acc   <= acc_n;
        cnt   <= cnt_n;
        if (close) begin
          o_ACC       <= sat_c;
          o_CLIP      <= gt || lt;
          o_FRAME_ERR <= cnt != CW'(NUM_SLOTS);
        end
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_frame_mixer.sv
// Scoreboard bench for ikaopll_frame_mixer: SHIFT=0 and SHIFT=2 instances
// share stimulus; monitors pop expected frame results on each strobe.
module tb_ikaopll_frame_mixer;

  typedef struct {
    int acc;
    bit clip;
    bit err;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncen;
  logic       fs;
  logic       valid;
  logic [0:0] grp;
  logic [8:0] data;
  logic [9:0] vol;
  logic [1:0] mute;

  logic        strb1, clip1, err1;
  logic [15:0] acc1;
  logic        strb2, clip2, err2;
  logic [15:0] acc2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int       v0 = 0;
  int       v1 = 0;
  bit [1:0] mu = 2'b00;

  exp_t q1[$];
  exp_t q2[$];
  bit   pend = 1'b0;
  exp_t p1;
  int   psum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ikaopll_frame_mixer dut1 (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phi1_NCEN_n(ncen),
    .i_FRAME_START(fs), .i_SLOT_VALID(valid), .i_SLOT_GROUP(grp),
    .i_DATA(data), .i_VOL(vol), .i_MUTE(mute),
    .o_ACC_STRB(strb1), .o_ACC(acc1), .o_CLIP(clip1),
    .o_FRAME_ERR(err1)
  );

  ikaopll_frame_mixer #(.SHIFT(2)) dut2 (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phi1_NCEN_n(ncen),
    .i_FRAME_START(fs), .i_SLOT_VALID(valid), .i_SLOT_GROUP(grp),
    .i_DATA(data), .i_VOL(vol), .i_MUTE(mute),
    .o_ACC_STRB(strb2), .o_ACC(acc2), .o_CLIP(clip2),
    .o_FRAME_ERR(err2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model2(input int sum);
    exp_t e;
    int   s;
    s      = sum >>> 2;
    e.clip = 1'b0;
    if (s > 32767) begin
      s = 32767; e.clip = 1'b1;
    end else if (s < -32768) begin
      s = -32768; e.clip = 1'b1;
    end
    e.acc = s;
    e.err = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  task automatic mon(input int which, input logic [15:0] a,
                     input logic c, input logic e);
    exp_t x;
    if ((which == 0 && q1.size() == 0) || (which == 1 && q2.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_strobe dut%0d: got acc %0d at cycle %0d, expected none",
               which + 1, $signed(a), cyc);
    end else begin
      if (which == 0) x = q1.pop_front();
      else            x = q2.pop_front();
      chk($sformatf("dut%0d_acc", which + 1), int'($signed(a)), x.acc);
      chk($sformatf("dut%0d_clip", which + 1), int'(c), int'(x.clip));
      chk($sformatf("dut%0d_err", which + 1), int'(e), int'(x.err));
      chk($sformatf("dut%0d_strobe_cycle", which + 1), cyc, x.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (strb1 === 1'b1) mon(0, acc1, clip1, err1);
    if (strb2 === 1'b1) mon(1, acc2, clip2, err2);
  end

  task automatic expect_close(input int a, input bit c, input bit e,
                              input int sum);
    pend   = 1'b1;
    p1.acc  = a;
    p1.clip = c;
    p1.err  = e;
    psum    = sum;
  endtask

  task automatic drive_slot(input bit f, input bit v, input int g,
                            input int d);
    exp_t p2;
    @(posedge clk);
    #1;
    ncen  = 1'b0;
    fs    = f;
    valid = v;
    grp   = g[0:0];
    data  = d[8:0];
    vol   = {v1[4:0], v0[4:0]};
    mute  = mu;
    if (f && pend) begin
      p1.cyc = cyc + 2;
      q1.push_back(p1);
      p2     = model2(psum);
      p2.err = p1.err;
      p2.cyc = cyc + 2;
      q2.push_back(p2);
      pend = 1'b0;
    end
  endtask

  task automatic slots(input int n, input bit first_fs, input int d,
                       input bit alt, input int inv_at, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          ncen  = 1'b1;
          fs    = 1'($urandom);
          valid = 1'($urandom);
          grp   = 1'($urandom);
          data  = 9'($urandom);
        end
      end
      drive_slot(i == 0 && first_fs, i != inv_at,
                 alt ? (i % 2) : 0, (i == inv_at) ? 99 : d);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_acc1"}, int'(acc1), 0);
    chk({tag, "_clip1"}, int'(clip1), 0);
    chk({tag, "_err1"}, int'(err1), 0);
    chk({tag, "_strb1"}, int'(strb1), 0);
    chk({tag, "_acc2"}, int'(acc2), 0);
    chk({tag, "_strb2"}, int'(strb2), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ncen  = 1'b0;
    fs    = 1'b0;
    valid = 1'b0;
    grp   = '0;
    data  = '0;
    vol   = '0;
    mute  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // single frame: 18 x 100 x 4
    v0 = 4;
    slots(18, 1, 100, 0, -1, -1);
    expect_close(7200, 0, 0, 7200);
    slots(10, 1, 100, 0, -1, -1);

    // reset mid-frame: partial frame must never be emitted
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    slots(18, 1, 100, 0, -1, -1);
    expect_close(7200, 0, 0, 7200);

    // saturation
    v0 = 15;
    slots(18, 1, 255, 0, -1, -1);
    expect_close(32767, 1, 0, 68850);
    slots(18, 1, -256, 0, -1, -1);
    expect_close(-32768, 1, 0, -69120);
    v0 = -16;
    slots(18, 1, -256, 0, -1, -1);
    expect_close(32767, 1, 0, 73728);

    // groups and mute
    v0 = 2;
    v1 = -3;
    slots(18, 1, 50, 1, -1, -1);
    expect_close(-450, 0, 0, -450);
    mu = 2'b10;
    slots(18, 1, 50, 1, -1, -1);
    expect_close(900, 0, 0, 900);

    // 17 valid slots plus one invalid
    mu = 2'b00;
    v0 = 3;
    slots(18, 1, 10, 0, 17, -1);
    expect_close(510, 0, 1, 510);

    // enable gating mid-frame
    slots(18, 1, 7, 0, -1, 8);
    expect_close(378, 0, 0, 378);

    // back-to-back frame starts
    drive_slot(1, 1, 0, 5);
    expect_close(15, 0, 1, 15);
    drive_slot(1, 1, 0, 5);
    expect_close(15, 0, 1, 15);
    drive_slot(1, 1, 0, 5);
    slots(17, 0, 1, 0, -1, -1);
    expect_close(66, 0, 0, 66);
    drive_slot(1, 1, 0, 0);
    repeat (4) drive_slot(0, 0, 0, 0);
    @(negedge clk);
    #1;

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ikaopll_frame_mixer.md
# ikaopll_frame_mixer

Parametrised successor to the fixed two-group (MO/RO) accumulated output path. The block sits after the operator/DAC stage and takes the time-multiplexed signed slot samples. It weights each sample by the signed volume of its group and accumulates one frame of `NUM_SLOTS` slots. Each completed frame is emitted as a saturated, strobed sample, with clip and frame-length error flags. Group count, widths, frame length and output scaling are all parameters.

## Interface
- `NUM_SLOTS`, 18: valid slots expected per frame.
- `NUM_GROUPS`, 2: number of volume groups. Group index width `GW = max(1, clog2(NUM_GROUPS))`.
- `DATA_WIDTH`, 9: signed slot sample width.
- `VOL_WIDTH`, 5: signed per-group volume width.
- `OUT_WIDTH`, 16: signed output width.
- `SHIFT`, 0: arithmetic right shift applied to the frame sum before saturation.
- `i_EMUCLK`  in  1: master clock. Single clock domain.
- `i_RST_n`  in  1: reset, asynchronous, active-low.
- `i_phi1_NCEN_n`  in  1: slot clock enable, negative logic. All state except the strobe advances only on edges where it is 0.
- `i_FRAME_START`  in  1: the current slot is the first slot of a frame.
- `i_SLOT_VALID`  in  1: the current slot carries a sample.
- `i_SLOT_GROUP`  in  GW: group of the current slot.
- `i_DATA`  in  DATA_WIDTH: signed sample.
- `i_VOL`  in  NUM_GROUPS*VOL_WIDTH: signed volumes, group g at bits `[g*VOL_WIDTH +: VOL_WIDTH]`.
- `i_MUTE`  in  NUM_GROUPS: per-group mute.
- `o_ACC_STRB`  out  1: new frame sample present. One `i_EMUCLK` cycle wide.
- `o_ACC`  out  OUT_WIDTH: saturated frame sum, signed.
- `o_CLIP`  out  1: saturation occurred on the current `o_ACC`.
- `o_FRAME_ERR`  out  1: the frame behind the current `o_ACC` did not have exactly `NUM_SLOTS` valid slots.

## Operation
- **Reset values:** all outputs are 0. The accumulator, slot counter and pipeline registers are 0. The state is IDLE.
- **Stage 1** (registered on each enabled edge):
  - `prod = i_DATA * vol[i_SLOT_GROUP]`, full signed width `DATA_WIDTH+VOL_WIDTH`.
  - `prod` is forced to 0 when `!i_SLOT_VALID`, when the group is muted, or when `i_SLOT_GROUP >= NUM_GROUPS`.
  - `valid` and `frame_start` flags are registered alongside `prod`.
- **Stage 2** (accumulator):
  - Width `AW = DATA_WIDTH+VOL_WIDTH+clog2(NUM_SLOTS+1)`. The accumulator never overflows internally.
  - Slot counter width is `clog2(NUM_SLOTS+2)`. It saturates at `NUM_SLOTS+1`.
- **IDLE state:**
  - Stage-2 data is discarded.
  - A stage-2 `frame_start` moves the state to ACCUM, loads the accumulator with that slot's `prod`, and loads the counter with its `valid`.
  - No strobe is produced.
- **ACCUM state, no frame start:** `acc += prod`, `cnt += valid`.
- **ACCUM state, stage-2 `frame_start`** (frame close):
  - `s = acc >>> SHIFT`, where `acc` is the value before this slot is added.
  - `o_ACC = sat(s)`, clamped to `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]`.
  - `o_CLIP = (s != o_ACC)`.
  - `o_FRAME_ERR = (cnt != NUM_SLOTS)`.
  - The accumulator and counter restart with this slot's `prod` and `valid`.
  - `o_ACC_STRB` pulses.
- **Frame length:**
  - A frame start arriving on every slot produces back-to-back closes.
  - Each such close strobes with `cnt` equal to 0 or 1, so `o_FRAME_ERR` = 1.
- **Output hold:** `o_ACC`, `o_CLIP` and `o_FRAME_ERR` hold until the next frame close. Volume or mute changes mid-frame affect only subsequent slots.
- **Reset mid-frame:** all state clears immediately. The partial frame is never emitted, and the next frame start re-enters from IDLE.

## Timing
- An input slot is sampled at enabled edge k (stage 1) and accumulated at enabled edge k+1.
- **Frame close latency:**
  - A frame start sampled at enabled edge k updates `o_ACC`, `o_CLIP` and `o_FRAME_ERR` at enabled edge k+1.
  - `o_ACC_STRB` is 1 for exactly the `i_EMUCLK` cycle following edge k+1, then 0.
  - The strobe is independent of further enables, so a continuously asserted enable still gives a one-cycle pulse.
- **Enable held high (1):** the whole block freezes, except that a strobe already raised still drops after one clock.
- **Throughput:** one slot per enabled edge. There is no backpressure.

## Test plan
- **Reset:** assert `i_RST_n`=0 mid-frame, release, then run two frames. Required: all outputs 0 during reset, no strobe at the first frame start, and the first strobe only at the second frame start.
- **Single frame:** defaults, 18 valid slots, `i_DATA`=+100, group 0, vol=+4. Required: `o_ACC`=7200, `o_CLIP`=0, `o_FRAME_ERR`=0, and the strobe is 1 clock wide, one enabled edge after the frame start.
- **Saturation:**
  - 18 slots of `i_DATA`=+255 with vol=+15 (sum 68850): `o_ACC`=32767, `o_CLIP`=1.
  - 18 slots of `i_DATA`=-256 with vol=+15: `o_ACC`=-32768, `o_CLIP`=1.
  - 18 slots of `i_DATA`=-256 with vol=-16: `o_ACC`=32767, `o_CLIP`=1.
- **Groups and mute:** slots alternate group 0/1 with `i_DATA`=+50, vol0=+2, vol1=-3, 9 slots each, giving -450. Muting group 1 gives +900. `SHIFT`=2 on the unmuted case gives -113 (arithmetic shift, floor).
- **Frame errors:**
  - 17 valid slots plus one `i_SLOT_VALID`=0 slot: `o_FRAME_ERR`=1, sum over the 17 slots.
  - A frame start on consecutive slots: back-to-back strobes, each with `o_FRAME_ERR`=1.
- **Enable gating:** hold `i_phi1_NCEN_n`=1 for 5 clocks mid-frame with toggling inputs. Required: the result is identical to the ungated run and no strobe occurs during the hold.
